uart_tx_fifo: RTL and testbench

//   Parametrised UART transmitter with an integrated TX FIFO and a frame-format generator.

---
 rtl/uart_tx_fifo.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated TX FIFO and frame-format generator (start, data LSB-first, optional parity, stop).
// Latency: a push into an empty FIFO with the line idle is popped on the next edge; txOUT falls one edge after that.
// Backpressure: none towards the source; a push while full is dropped and flagged on overflowOUT, unless a pop happens in the same cycle.
//
// Ports:
//   clkIN        system clock, rising edge
//   nResetIN     asynchronous active-low reset; aborts any frame and flushes the FIFO
//   dataIN       word to queue (dataBits wide)
//   sendIN       push strobe, one word per cycle while high
//   txOUT        serial line, idle high
//   nBusyOUT     high when the FIFO is empty and no frame is in flight
//   fullOUT      FIFO full
//   emptyOUT     FIFO empty
//   levelOUT     FIFO occupancy
//   overflowOUT  one-cycle pulse when a push was dropped
module uart_tx_fifo #(
  parameter int unsigned clkFreq    = 48_000_000,
  parameter int unsigned baudRate   = 9600,
  parameter int unsigned dataBits   = 8,
  parameter int unsigned parityMode = 0,
  parameter int unsigned stopBits   = 1,
  parameter int unsigned fifoDepth  = 16
) (
  input  logic                         clkIN,
  input  logic                         nResetIN,
  input  logic [dataBits-1:0]          dataIN,
  input  logic                         sendIN,
  output logic                         txOUT,
  output logic                         nBusyOUT,
  output logic                         fullOUT,
  output logic                         emptyOUT,
  output logic [$clog2(fifoDepth):0]   levelOUT,
  output logic                         overflowOUT
);

  localparam int unsigned DIV      = clkFreq / baudRate;
  localparam int unsigned STOP_LEN = stopBits * DIV;
  // STOP is the longest state, so its counter width covers every bit period.
  localparam int unsigned CNT_W    = $clog2(STOP_LEN);
  localparam int unsigned PTR_W    = $clog2(fifoDepth);
  localparam int unsigned LVL_W    = PTR_W + 1;
  localparam int unsigned BIT_W    = $clog2(dataBits);
  localparam bit          HAS_PAR  = (parityMode != 0);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(dataBits - 1);
  localparam logic [LVL_W-1:0] DEPTH     = LVL_W'(fifoDepth);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and occupancy
  // ---------------------------------------------------------------------------
  logic [dataBits-1:0] mem_q [fifoDepth];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [LVL_W-1:0]    level_q;
  logic [LVL_W-1:0]    level_d;
  logic                full_q;
  logic                empty_q;
  logic                overflow_q;

  // ---------------------------------------------------------------------------
  // Serialiser state
  // ---------------------------------------------------------------------------
  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BIT_W-1:0]    bit_q;
  logic [dataBits-1:0] shreg_q;
  logic                par_q;
  logic                tx_q;
  logic                nbusy_q;
  logic                tx_d;

  logic                pop_d;
  logic                push_d;
  logic [dataBits-1:0] pop_word_d;
  logic                pop_par_d;

  // Pop decision uses the registered level, so a push into an empty FIFO is
  // only visible to the serialiser one cycle later.
  always_comb begin
    pop_d = 1'b0;
    if (!empty_q) begin
      if (state_q == S_IDLE) begin
        pop_d = 1'b1;
      end else if ((state_q == S_STOP) && (cnt_q == STOP_LAST)) begin
        pop_d = 1'b1;
      end
    end
  end

  // A full FIFO still accepts a word when the head leaves in the same cycle:
  // the write lands in the slot being vacated.
  assign push_d     = sendIN && (!full_q || pop_d);
  assign pop_word_d = mem_q[rd_ptr_q];

  // Even parity makes the total count of ones even; odd makes it odd.
  always_comb begin
    pop_par_d = ^pop_word_d;
    if (parityMode == 1) begin
      pop_par_d = ~^pop_word_d;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push_d, pop_d})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clkIN) begin
    if (push_d) begin
      mem_q[wr_ptr_q] <= dataIN;
    end
  end

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push_d) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_d) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q    <= level_d;
      full_q     <= (level_d == DEPTH);
      empty_q    <= (level_d == '0);
      overflow_q <= sendIN && full_q && !pop_d;
    end
  end

  // Line level follows the state with one register stage, so every state
  // keeps its exact length on the pin.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_q[0];
      S_PARITY: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
  end

  // Baud counter restarts on every state/bit entry so there is no drift.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      nbusy_q <= 1'b1;
    end else begin
      tx_q    <= tx_d;
      nbusy_q <= empty_q && (state_q == S_IDLE);
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (pop_d) begin
            state_q <= S_START;
            shreg_q <= pop_word_d;
            par_q   <= pop_par_d;
          end
        end
        S_START: begin
          if (cnt_q == DIV_LAST) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q   <= '0;
            shreg_q <= shreg_q >> 1;
            if (bit_q == BIT_LAST) begin
              state_q <= HAS_PAR ? S_PARITY : S_STOP;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (cnt_q == DIV_LAST) begin
            state_q <= S_STOP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == STOP_LAST) begin
            cnt_q <= '0;
            // Back-to-back frames: the next start bit follows the last stop cycle directly.
            if (pop_d) begin
              state_q <= S_START;
              shreg_q <= pop_word_d;
              par_q   <= pop_par_d;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign txOUT       = tx_q;
  assign nBusyOUT    = nbusy_q;
  assign fullOUT     = full_q;
  assign emptyOUT    = empty_q;
  assign levelOUT    = level_q;
  assign overflowOUT = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: six configurations side by side, frames decoded cycle-exact against a queue of expected words.
// Latency: checks push-to-fall timing, nBusyOUT timing, inter-frame gaps.
// Backpressure: exercises overflow drop, full-with-pop acceptance and reset mid-frame.
module tb_uart_tx_fifo;

  localparam int NI = 6;
  // config per instance: 8N1, 8E1, 8O1, 7E2, 9N1 (DIV=10), 5N1 (DIV=2)
  localparam int CDB [NI]  = '{8, 8, 8, 7, 9, 5};
  localparam int CPAR[NI]  = '{0, 2, 1, 2, 0, 0};
  localparam int CSB [NI]  = '{1, 1, 1, 2, 1, 1};
  localparam int CDIV[NI]  = '{10, 10, 10, 10, 10, 2};

  typedef struct {
    logic [8:0] w;
    int         gap;   // required idle cycles before this frame, -1 = any
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NI-1:0]   send_w, tx_w, nbusy_w, full_w, empty_w, ovf_w;
  logic [8:0]      din [NI];
  logic [4:0]      lvl [NI];

  exp_t            expq [NI][$];
  bit              cap [NI];
  int              cnt [NI];
  int              idle [NI];
  int              gap_obs [NI];
  logic [127:0]    obs [NI];

  int tests = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.clkFreq(1_000_000), .baudRate(100_000), .dataBits(8), .parityMode(0), .stopBits(1), .fifoDepth(16)) u_8n1 (
    .clkIN(clk), .nResetIN(rst_n), .dataIN(din[0][7:0]), .sendIN(send_w[0]), .txOUT(tx_w[0]), .nBusyOUT(nbusy_w[0]),
    .fullOUT(full_w[0]), .emptyOUT(empty_w[0]), .levelOUT(lvl[0]), .overflowOUT(ovf_w[0]));
  uart_tx_fifo #(.clkFreq(1_000_000), .baudRate(100_000), .dataBits(8), .parityMode(2), .stopBits(1), .fifoDepth(16)) u_8e1 (
    .clkIN(clk), .nResetIN(rst_n), .dataIN(din[1][7:0]), .sendIN(send_w[1]), .txOUT(tx_w[1]), .nBusyOUT(nbusy_w[1]),
    .fullOUT(full_w[1]), .emptyOUT(empty_w[1]), .levelOUT(lvl[1]), .overflowOUT(ovf_w[1]));
  uart_tx_fifo #(.clkFreq(1_000_000), .baudRate(100_000), .dataBits(8), .parityMode(1), .stopBits(1), .fifoDepth(16)) u_8o1 (
    .clkIN(clk), .nResetIN(rst_n), .dataIN(din[2][7:0]), .sendIN(send_w[2]), .txOUT(tx_w[2]), .nBusyOUT(nbusy_w[2]),
    .fullOUT(full_w[2]), .emptyOUT(empty_w[2]), .levelOUT(lvl[2]), .overflowOUT(ovf_w[2]));
  uart_tx_fifo #(.clkFreq(1_000_000), .baudRate(100_000), .dataBits(7), .parityMode(2), .stopBits(2), .fifoDepth(16)) u_7e2 (
    .clkIN(clk), .nResetIN(rst_n), .dataIN(din[3][6:0]), .sendIN(send_w[3]), .txOUT(tx_w[3]), .nBusyOUT(nbusy_w[3]),
    .fullOUT(full_w[3]), .emptyOUT(empty_w[3]), .levelOUT(lvl[3]), .overflowOUT(ovf_w[3]));
  uart_tx_fifo #(.clkFreq(1_000_000), .baudRate(100_000), .dataBits(9), .parityMode(0), .stopBits(1), .fifoDepth(16)) u_9n1 (
    .clkIN(clk), .nResetIN(rst_n), .dataIN(din[4][8:0]), .sendIN(send_w[4]), .txOUT(tx_w[4]), .nBusyOUT(nbusy_w[4]),
    .fullOUT(full_w[4]), .emptyOUT(empty_w[4]), .levelOUT(lvl[4]), .overflowOUT(ovf_w[4]));
  uart_tx_fifo #(.clkFreq(1_000_000), .baudRate(500_000), .dataBits(5), .parityMode(0), .stopBits(1), .fifoDepth(16)) u_5n1 (
    .clkIN(clk), .nResetIN(rst_n), .dataIN(din[5][4:0]), .sendIN(send_w[5]), .txOUT(tx_w[5]), .nBusyOUT(nbusy_w[5]),
    .fullOUT(full_w[5]), .emptyOUT(empty_w[5]), .levelOUT(lvl[5]), .overflowOUT(ovf_w[5]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int flen(input int i);
    return (1 + CDB[i] + ((CPAR[i] != 0) ? 1 : 0) + CSB[i]) * CDIV[i];
  endfunction

  // Expected line level per cycle of one frame, bit k = cycle k after the fall.
  function automatic logic [127:0] build(input int i, input logic [8:0] w);
    logic [127:0] v;
    int           pos;
    logic         p;
    v   = '0;
    pos = 0;
    p   = 1'b0;
    for (int c = 0; c < CDIV[i]; c++) begin v[pos] = 1'b0; pos++; end
    for (int b = 0; b < CDB[i]; b++) begin
      p = p ^ w[b];
      for (int c = 0; c < CDIV[i]; c++) begin v[pos] = w[b]; pos++; end
    end
    if (CPAR[i] != 0) begin
      if (CPAR[i] == 1) p = ~p;
      for (int c = 0; c < CDIV[i]; c++) begin v[pos] = p; pos++; end
    end
    for (int c = 0; c < CSB[i] * CDIV[i]; c++) begin v[pos] = 1'b1; pos++; end
    return v;
  endfunction

  // Frame decoder: captures every cycle of each frame and compares it with the queue head.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        cap[i]  = 1'b0;
        idle[i] = 0;
      end else begin
        if (!cap[i]) begin
          if (tx_w[i] == 1'b0) begin
            cap[i]     = 1'b1;
            obs[i]     = '0;
            cnt[i]     = 1;
            gap_obs[i] = idle[i];
          end else if (idle[i] < 1000) begin
            idle[i]++;
          end
        end else begin
          obs[i][cnt[i]] = tx_w[i];
          cnt[i]++;
        end
        if (cap[i] && cnt[i] == flen(i)) begin
          cap[i]  = 1'b0;
          idle[i] = 0;
          if (expq[i].size() == 0) begin
            chk($sformatf("unexpected_frame%0d", i), obs[i], '0);
          end else begin
            e = expq[i].pop_front();
            chk($sformatf("frame%0d_w%0h", i, e.w), obs[i], build(i, e.w));
            if (e.gap >= 0) chk($sformatf("gap%0d_w%0h", i, e.gap), gap_obs[i], e.gap);
          end
        end
      end
    end
  end

  // Present a word for one edge; acc says whether the word must come out.
  task automatic drive(input int i, input logic [8:0] w, input int gap, input bit acc);
    exp_t e;
    send_w[i] = 1'b1;
    din[i]    = w;
    if (acc) begin
      e.w   = w;
      e.gap = gap;
      expq[i].push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic push(input int i, input logic [8:0] w, input int gap);
    drive(i, w, gap, 1'b1);
    send_w[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (!(expq[i].size() == 0 && !cap[i] && nbusy_w[i]) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      chk($sformatf("timeout%0d", i), 0, 1);
    end else begin
      chk($sformatf("idle_empty%0d", i), empty_w[i], 1);
      chk($sformatf("idle_full%0d", i), full_w[i], 0);
      chk($sformatf("idle_level%0d", i), lvl[i], 0);
      chk($sformatf("idle_ovf%0d", i), ovf_w[i], 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int novf;
    rst_n  = 1'b0;
    send_w = '0;
    for (int i = 0; i < NI; i++) din[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_w[0], 1);
    chk("rst_nbusy", nbusy_w[0], 1);
    chk("rst_full", full_w[0], 0);
    chk("rst_empty", empty_w[0], 1);
    chk("rst_level", lvl[0], 0);
    chk("rst_ovf", ovf_w[0], 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0x55: pop one edge after the push, fall one edge after that.
    push(0, 9'h055, -1);
    chk("t55_level_after_push", lvl[0], 1);
    chk("t55_tx_after_push", tx_w[0], 1);
    @(negedge clk);
    chk("t55_tx_pop_edge", tx_w[0], 1);
    chk("t55_level_pop_edge", lvl[0], 0);
    chk("t55_nbusy_low", nbusy_w[0], 0);
    @(negedge clk);
    chk("t55_tx_fall", tx_w[0], 0);
    repeat (99) @(negedge clk);
    chk("t55_nbusy_still_low", nbusy_w[0], 0);
    @(negedge clk);
    chk("t55_nbusy_high", nbusy_w[0], 1);
    wait_idle(0);

    // Parity and width corners.
    push(1, 9'h007, -1); wait_idle(1);
    push(2, 9'h007, -1); wait_idle(2);
    push(3, 9'h041, -1); wait_idle(3);
    push(4, 9'h1A5, -1); push(4, 9'h05A, 0); wait_idle(4);
    drive(5, 9'h015, -1, 1'b1);
    drive(5, 9'h00A, 0, 1'b1);
    drive(5, 9'h01F, 0, 1'b1);
    send_w[5] = 1'b0;
    wait_idle(5);

    // Burst of 18: 17 accepted, 18th dropped with one overflow pulse.
    novf = 0;
    for (int k = 0; k < 18; k++) begin
      drive(0, 9'(8'h80 + k), (k == 0) ? -1 : 0, k < 17);
      if (ovf_w[0]) novf++;
      if (k == 16) begin
        chk("burst_full", full_w[0], 1);
        chk("burst_level16", lvl[0], 16);
      end
    end
    send_w[0] = 1'b0;
    repeat (83) begin
      @(negedge clk);
      if (ovf_w[0]) novf++;
    end
    chk("burst_ovf_pulses", novf, 1);
    // Push on the pop edge of the second frame while still full.
    drive(0, 9'h099, 0, 1'b1);
    send_w[0] = 1'b0;
    chk("fullpop_level", lvl[0], 16);
    chk("fullpop_full", full_w[0], 1);
    chk("fullpop_ovf", ovf_w[0], 0);
    wait_idle(0);

    // Push exactly on the last stop cycle into an empty FIFO: one idle cycle.
    push(0, 9'h05A, -1);
    repeat (100) @(negedge clk);
    push(0, 9'h0C3, 1);
    wait_idle(0);

    // Reset during data bit 3 with a second word still queued.
    drive(0, 9'h03C, -1, 1'b1);
    drive(0, 9'h011, -1, 1'b1);
    send_w[0] = 1'b0;
    repeat (44) @(negedge clk);
    chk("midrst_level_before", lvl[0], 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx_w[0], 1);
    chk("midrst_level", lvl[0], 0);
    chk("midrst_empty", empty_w[0], 1);
    expq[0].delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(0, 9'h0A3, -1);
    wait_idle(0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
